muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_decode.sv | 15 +
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and decode constants for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

  function automatic logic op_a_signed(mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div_op(mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_decode.sv
// Combinational instruction-field decode for M-extension operations.
module mdu_decode
  import mdu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [6:0] funct7_i,
  input  logic [2:0] funct3_i,
  output logic       is_mdu_o,
  output mdu_op_e    op_o
);

  assign is_mdu_o = (alu_op_i == ALUOP_RTYPE) && (funct7_i == FUNCT7_MULDIV);
  assign op_o     = mdu_op_e'(funct3_i);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on magnitudes with sign fix-up on completion.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            is_mdu_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  logic    is_mdu;
  mdu_op_e dec_op;

  mdu_decode u_decode (
    .alu_op_i (ALUOp),
    .funct7_i (Funct7),
    .funct3_i (Funct3),
    .is_mdu_o (is_mdu),
    .op_o     (dec_op)
  );

  assign is_mdu_o = is_mdu;

  mdu_state_e          state_q, state_d;
  mdu_op_e             op_q, op_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic                neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand magnitudes and signs for the incoming request
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    a_neg = op_a_signed(dec_op) && op_a_i[XLEN-1];
    b_neg = op_b_signed(dec_op) && op_b_i[XLEN-1];
    a_mag = a_neg ? -op_a_i : op_a_i;
    b_mag = b_neg ? -op_b_i : op_b_i;
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum, div_trial;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] step;
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_trial = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_trial[XLEN-1:0] - b_q;
    if (is_div_op(op_q)) begin
      step = (div_trial >= {1'b0, b_q}) ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                                        : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_res;
  always_comb begin
    prod = neg_q  ? -acc_q : acc_q;
    quo  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = dz_q ? '1 : quo;
      default:                      final_res = dz_q ? a_q : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && is_mdu && !flush_i) begin
          state_d = ST_CALC;
          op_d    = dec_op;
          cnt_d   = '0;
          acc_d   = {{XLEN{1'b0}}, a_mag};
          a_d     = op_a_i;
          b_d     = b_mag;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dz_d    = (op_b_i == '0);
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          done_d   = 1'b1;
          result_d = final_res;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, decoupled monitor.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i;
  logic [1:0]      alu_op;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b;
  logic            flush;
  logic            is_mdu_o, busy_o, done_o;
  logic [XLEN-1:0] result_o;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .ALUOp    (alu_op),
    .Funct7   (funct7),
    .Funct3   (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .flush_i  (flush),
    .is_mdu_o (is_mdu_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          acc;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e_mon;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_last = '0;
  string       names[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: pops expectations on done_o, checks latency and busy_o while in flight
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done result=%h expected=no done", result_o);
        end else begin
          e_mon = sb_q.pop_front();
          check({e_mon.name, "_result"}, result_o, e_mon.res);
          check({e_mon.name, "_latency"}, 32'(cyc - e_mon.acc), 32'(XLEN + 1));
          check({e_mon.name, "_busy_at_done"}, {31'h0, busy_o}, 32'h0);
          exp_last = e_mon.res;
        end
      end else if (sb_q.size() != 0 && (cyc - sb_q[0].acc) <= int'(XLEN)) begin
        check({sb_q[0].name, "_busy"}, {31'h0, busy_o}, 32'h1);
      end
    end
  end

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i = 1'b1;
    alu_op  = 2'b10;
    funct7  = 7'b0000001;
    funct3  = op;
    op_a    = a;
    op_b    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold);
    exp_t e;
    int   n;
    drive_req(op, a, b);
    e.res  = ref_model(op, a, b);
    e.acc  = cyc;
    e.name = names[op];
    sb_q.push_back(e);
    if (!hold) start_i = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    start_i = 1'b0;
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no done expected=done", names[op]);
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    alu_op  = 2'b10;
    funct7  = 7'b0000001;
    funct3  = 3'd0;
    op_a    = '0;
    op_b    = '0;
    flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'h0, busy_o}, 32'h0);
    check("reset_done", {31'h0, done_o}, 32'h0);
    check("reset_result", result_o, 32'h0);
    check("is_mdu_in_reset", {31'h0, is_mdu_o}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases; the first holds start_i high through the DONE cycle
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(3'd5, 32'd100, 32'd0, 1'b0);
    do_op(3'd7, 32'd100, 32'd0, 1'b0);
    do_op(3'd4, 32'hFFFF_FF9C, 32'd0, 1'b0);
    do_op(3'd6, 32'hFFFF_FF9C, 32'd0, 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush on the tenth CALC cycle
    drive_req(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc_busy", {31'h0, busy_o}, 32'h0);
    check("flush_calc_done", {31'h0, done_o}, 32'h0);
    check("flush_calc_result", result_o, exp_last);
    do_op(3'd5, 32'd1000, 32'd7, 1'b0);

    // Flush coinciding with the DONE cycle wins over completion
    drive_req(3'd3, 32'hDEAD_BEEF, 32'h0000_0100);
    start_i = 1'b0;
    repeat (33) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done_done", {31'h0, done_o}, 32'h0);
    check("flush_done_busy", {31'h0, busy_o}, 32'h0);
    check("flush_done_result", result_o, exp_last);
    repeat (40) @(negedge clk);

    // Reset mid-CALC
    drive_req(3'd4, 32'd12345, 32'd17);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_busy", {31'h0, busy_o}, 32'h0);
    check("midreset_done", {31'h0, done_o}, 32'h0);
    check("midreset_result", result_o, 32'h0);
    exp_last = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Non-MDU encodings are never accepted
    @(negedge clk);
    start_i = 1'b1;
    funct7  = 7'b0000000;
    #1;
    check("decode_f7_zero", {31'h0, is_mdu_o}, 32'h0);
    @(posedge clk);
    #1;
    check("no_accept_busy", {31'h0, busy_o}, 32'h0);
    @(negedge clk);
    funct7 = 7'b0000001;
    alu_op = 2'b00;
    #1;
    check("decode_aluop", {31'h0, is_mdu_o}, 32'h0);
    @(posedge clk);
    #1;
    check("no_accept_busy2", {31'h0, busy_o}, 32'h0);
    start_i = 1'b0;
    alu_op  = 2'b10;
    #1;
    check("decode_hit", {31'h0, is_mdu_o}, 32'h1);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
